// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: op codes, FSM states and
// the constants used by the special-case results.
package div_pkg;

  localparam int XLEN     = 32;
  localparam int DIV_ITER = 32;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } div_state_e;

  function automatic logic [31:0] abs_val(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor if it fits.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            dvd_msb,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] trial;
  logic [XLEN:0] diff;

  // The trial keeps rem_in's top bit so divisors above 2^(XLEN-1) still work.
  assign trial   = {rem_in, dvd_msb};
  assign diff    = trial - {1'b0, dvs};
  assign q_bit   = (trial >= {1'b0, dvs});
  assign rem_out = q_bit ? diff[XLEN-1:0] : trial[XLEN-1:0];

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU controller: 32 restoring iterations on
// magnitudes, sign fix-up at the end, start/busy/done handshake.
module div_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  import div_pkg::*;

  div_state_e state, state_nx;

  logic [1:0]      op_q;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] rem, dvd, dvs;
  logic [CNT_W-1:0] cnt;

  logic            in_signed, b_zero, overflow, special, accept, last_iter;
  logic [XLEN-1:0] rem_nx, quot_fin, special_res, fixed_res;
  logic            q_bit;

  assign in_signed = ~op[0];
  assign b_zero    = (b == '0);
  assign overflow  = in_signed && (a == INT_MIN) && (b == '1);
  assign special   = b_zero || overflow;
  assign accept    = (state == S_IDLE) && start && !flush;
  assign last_iter = (cnt == CNT_W'(DIV_ITER - 1));

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem),
    .dvd_msb (dvd[XLEN-1]),
    .dvs     (dvs),
    .rem_out (rem_nx),
    .q_bit   (q_bit)
  );

  // Dividend bits shift out the top while quotient bits fill in from below.
  assign quot_fin = {dvd[XLEN-2:0], q_bit};

  always_comb begin
    special_res = '0;
    if (b_zero)
      special_res = op[1] ? a : DIV_ZERO_Q;
    else
      special_res = op[1] ? '0 : INT_MIN;
  end

  always_comb begin
    fixed_res = op_q[1] ? rem_nx : quot_fin;
    if (!op_q[0]) begin
      if (op_q[1] && a_neg)
        fixed_res = -rem_nx;
      else if (!op_q[1] && (a_neg ^ b_neg))
        fixed_res = -quot_fin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept)
          state_nx = special ? S_DONE : S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (flush)
          state_nx = S_IDLE;
        else if (last_iter)
          state_nx = S_DONE;
      end
      S_DONE: begin
        busy     = 1'b1;
        done     = !flush;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: operands are captured once on accept; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      rem    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (accept) begin
      op_q  <= op;
      a_neg <= in_signed & a[XLEN-1];
      b_neg <= in_signed & b[XLEN-1];
      dvd   <= in_signed ? abs_val(a) : a;
      dvs   <= in_signed ? abs_val(b) : b;
      rem   <= '0;
      cnt   <= '0;
      if (special)
        result <= special_res;
    end else if (state == S_CALC && !flush) begin
      rem <= rem_nx;
      dvd <= quot_fin;
      cnt <= cnt + 1'b1;
      if (last_iter)
        result <= fixed_res;
    end
  end

endmodule
